// File: rtl/led_pattern_ctrl_pkg.sv
// led_pattern_ctrl_pkg: mode, state and direction encodings plus LED start
// values shared by the LED pattern sequencer and its prescaler.
package led_pattern_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_RIPL = 2'b00,
      MODE_RIPR = 2'b01,
      MODE_BNC  = 2'b10,
      MODE_BLNK = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10
   } state_e;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   localparam logic [7:0] LED_START_L = 8'h01;
   localparam logic [7:0] LED_START_R = 8'h80;

   // Value loaded into the LED register when a mode is (re)selected.
   function automatic logic [7:0] start_led(input mode_e m);
      case (m)
         MODE_RIPR: return LED_START_R;
         MODE_BLNK: return 8'h00;
         default:   return LED_START_L;
      endcase
   endfunction

endpackage

// File: rtl/led_pattern_ctrl_tick_prescaler.sv
// tick_prescaler: step-period counter. Period is DIV_BASE << speed clk cycles;
// the >= compare makes a mid-count speed decrease tick on the next enabled cycle.
module tick_prescaler #(
   parameter int unsigned DIV_BASE = 4,
   parameter int unsigned CNT_W    = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       clr,
   input  logic [1:0] speed,
   output logic       tick
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] period_m1;

   // Terminal count for the selected speed and the resulting tick.
   always_comb begin
      period_m1 = (CNT_W'(DIV_BASE) << speed) - CNT_W'(1);
      tick      = en && (cnt >= period_m1);
   end

   // Counter: cleared by reset/clr, advances only while enabled, restarts on tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         if (tick) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: 8-LED pattern sequencer (ripple-left, ripple-right, bounce,
// blink) with speed select and pause. Optional macro LED_PAT_BOUNCE_EN enables
// bounce for mode 10; without it mode 10 behaves as ripple-left.
import led_pattern_ctrl_pkg::*;

module led_pattern_ctrl #(
   parameter int unsigned DIV_BASE = 4,
   parameter int unsigned CNT_W    = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] mode,
   input  logic [1:0] speed,
   input  logic       pause,
   output logic [7:0] led,
   output logic       step
);

   state_e state;
   mode_e  mode_in;
   mode_e  mode_q;
   logic   mode_chg;
   logic   presc_en;
   logic   presc_clr;
   logic   tick;
`ifdef LED_PAT_BOUNCE_EN
   dir_e   dir;
`endif

   // Pattern actually applied for a registered mode selection.
   function automatic mode_e pat_mode(input mode_e m);
`ifdef LED_PAT_BOUNCE_EN
      return m;
`else
      return (m == MODE_BNC) ? MODE_RIPL : m;
`endif
   endfunction

   // Mode change has priority over pause; the prescaler only runs when neither applies.
   always_comb begin
      mode_in   = mode_e'(mode);
      mode_chg  = (state != ST_LOAD) && (mode_in != mode_q);
      presc_clr = (state == ST_LOAD);
      presc_en  = (state != ST_LOAD) && !mode_chg && !pause;
   end

   tick_prescaler #(
      .DIV_BASE (DIV_BASE),
      .CNT_W    (CNT_W)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (presc_en),
      .clr   (presc_clr),
      .speed (speed),
      .tick  (tick)
   );

   // Sequencer FSM with registered LED pattern and step pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_RUN;
         mode_q <= MODE_RIPL;
         led    <= LED_START_L;
         step   <= 1'b0;
`ifdef LED_PAT_BOUNCE_EN
         dir    <= DIR_LEFT;
`endif
      end else begin
         step <= 1'b0;
         case (state)
            ST_LOAD: begin
               led    <= start_led(mode_in);
               mode_q <= mode_in;
`ifdef LED_PAT_BOUNCE_EN
               dir    <= DIR_LEFT;
`endif
               state  <= pause ? ST_PAUSE : ST_RUN;
            end
            ST_RUN, ST_PAUSE: begin
               if (mode_chg) begin
                  state <= ST_LOAD;
               end else if (pause) begin
                  state <= ST_PAUSE;
               end else begin
                  state <= ST_RUN;
                  if (tick) begin
                     step <= 1'b1;
                     case (pat_mode(mode_q))
                        MODE_RIPR: led <= {led[0], led[7:1]};
                        MODE_BLNK: led <= ~led;
`ifdef LED_PAT_BOUNCE_EN
                        // End values reverse direction without repeating the end LED.
                        MODE_BNC: begin
                           if (dir == DIR_LEFT) begin
                              if (led[7]) begin
                                 dir <= DIR_RIGHT;
                                 led <= 8'h40;
                              end else begin
                                 led <= {led[6:0], 1'b0};
                              end
                           end else begin
                              if (led[0]) begin
                                 dir <= DIR_LEFT;
                                 led <= 8'h02;
                              end else begin
                                 led <= {1'b0, led[7:1]};
                              end
                           end
                        end
`endif
                        default:   led <= {led[6:0], led[7]};
                     endcase
                  end
               end
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

endmodule
